// File: rtl/vc_alloc_rr_pkg.sv
// Shared types and width helpers for the router's VC allocator.
// Default geometry: five ports (N,E,S,W,R), two VCs per port.
package vc_alloc_rr_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_PORTS_DEF  = 5;
    localparam int NUM_VCS_DEF    = 2;
    localparam int PORT_BITS_DEF  = clog2_min1(NUM_PORTS_DEF);
    localparam int VC_ID_BITS_DEF = clog2_min1(NUM_VCS_DEF);

    typedef logic [PORT_BITS_DEF-1:0]  dir_t;
    typedef logic [VC_ID_BITS_DEF-1:0] vc_id_t;

    localparam dir_t DIR_N = dir_t'(0);
    localparam dir_t DIR_E = dir_t'(1);
    localparam dir_t DIR_S = dir_t'(2);
    localparam dir_t DIR_W = dir_t'(3);
    localparam dir_t DIR_R = dir_t'(4);

    typedef struct packed {
        dir_t   port;
        vc_id_t vc;
    } vc_owner_t;

endpackage

// File: rtl/vc_alloc_rr_rr_arb.sv
// Round-robin arbiter: one-hot grant starting from the pointer.
// The pointer moves past the winner only when advance_i is set.
module rr_arb #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            win;
    int            idx;

    // first requester at or after the pointer, wrapping
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) gnt_o[win] = 1'b1;
        ptr_d = ptr_q;
        if (advance_i && found) ptr_d = PW'((win + 1) % N);
    end

    // pointer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vc_alloc_rr.sv
// Separable input-first/output-second round-robin VC allocator.
// Optional VA_VC_FREE_OBS_EN exposes per-output-VC free flags.
module vc_alloc_rr
    import vc_alloc_rr_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int NUM_VCS    = NUM_VCS_DEF,
    parameter int PORT_BITS  = clog2_min1(NUM_PORTS),
    parameter int VC_ID_BITS = clog2_min1(NUM_VCS)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  req_valid       [NUM_PORTS][NUM_VCS],
    input  logic [PORT_BITS-1:0]  req_dir         [NUM_PORTS][NUM_VCS],
    input  logic [NUM_VCS-1:0]    req_vc_mask     [NUM_PORTS][NUM_VCS],
    input  logic                  unlock_vc       [NUM_PORTS][NUM_VCS],
    output logic                  vc_allocated    [NUM_PORTS][NUM_VCS],
    output logic [VC_ID_BITS-1:0] vc_allocated_id [NUM_PORTS][NUM_VCS]
`ifdef VA_VC_FREE_OBS_EN
    ,
    output logic                  out_vc_free     [NUM_PORTS][NUM_VCS]
`endif
);
    localparam int NI = NUM_PORTS * NUM_VCS;

    logic                  busy_q  [NUM_PORTS][NUM_VCS];
    logic                  busy_d  [NUM_PORTS][NUM_VCS];
    logic [PORT_BITS-1:0]  own_p_q [NUM_PORTS][NUM_VCS];
    logic [PORT_BITS-1:0]  own_p_d [NUM_PORTS][NUM_VCS];
    logic [VC_ID_BITS-1:0] own_v_q [NUM_PORTS][NUM_VCS];
    logic [VC_ID_BITS-1:0] own_v_d [NUM_PORTS][NUM_VCS];
    logic                  held_q  [NUM_PORTS][NUM_VCS];
    logic                  held_d  [NUM_PORTS][NUM_VCS];
    logic                  alloc_q [NUM_PORTS][NUM_VCS];
    logic                  alloc_d [NUM_PORTS][NUM_VCS];
    logic [VC_ID_BITS-1:0] id_q    [NUM_PORTS][NUM_VCS];
    logic [VC_ID_BITS-1:0] id_d    [NUM_PORTS][NUM_VCS];

    logic                  elig    [NUM_PORTS][NUM_VCS];
    logic [NUM_VCS-1:0]    in_req  [NUM_PORTS][NUM_VCS];
    logic [NUM_VCS-1:0]    in_gnt  [NUM_PORTS][NUM_VCS];
    logic                  in_win  [NUM_PORTS][NUM_VCS];
    logic [VC_ID_BITS-1:0] win_id  [NUM_PORTS][NUM_VCS];
    logic [NI-1:0]         out_req [NUM_PORTS][NUM_VCS];
    logic [NI-1:0]         out_gnt [NUM_PORTS][NUM_VCS];
    logic                  out_adv [NUM_PORTS][NUM_VCS];

    // stage-1 requests: legal, unheld, permitted and free output VCs
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                elig[p][v] = req_valid[p][v] && !held_q[p][v]
                          && (int'(req_dir[p][v]) < NUM_PORTS)
                          && (int'(req_dir[p][v]) != p);
                in_req[p][v] = '0;
                for (int q = 0; q < NUM_PORTS; q++) begin
                    if (int'(req_dir[p][v]) == q) begin
                        for (int k = 0; k < NUM_VCS; k++) begin
                            in_req[p][v][k] = elig[p][v]
                                           && req_vc_mask[p][v][k]
                                           && !busy_q[q][k];
                        end
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in_p
        for (genvar v = 0; v < NUM_VCS; v++) begin : g_in_v
            rr_arb #(.N(NUM_VCS)) u_in_arb (
                .clk_i     (clk),
                .rst_i     (arst),
                .req_i     (in_req[p][v]),
                .advance_i (in_win[p][v]),
                .gnt_o     (in_gnt[p][v])
            );
        end
    end

    // stage-2 requests: every input candidate aimed at this output VC
    always_comb begin
        for (int q = 0; q < NUM_PORTS; q++) begin
            for (int k = 0; k < NUM_VCS; k++) begin
                out_req[q][k] = '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    for (int v = 0; v < NUM_VCS; v++) begin
                        out_req[q][k][p*NUM_VCS+v] = in_gnt[p][v][k]
                            && (int'(req_dir[p][v]) == q);
                    end
                end
                out_adv[q][k] = |out_gnt[q][k];
            end
        end
    end

    for (genvar q = 0; q < NUM_PORTS; q++) begin : g_out_p
        for (genvar k = 0; k < NUM_VCS; k++) begin : g_out_v
            rr_arb #(.N(NI)) u_out_arb (
                .clk_i     (clk),
                .rst_i     (arst),
                .req_i     (out_req[q][k]),
                .advance_i (out_adv[q][k]),
                .gnt_o     (out_gnt[q][k])
            );
        end
    end

    // final grant per input VC and binary id of its stage-1 choice
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                in_win[p][v] = 1'b0;
                win_id[p][v] = '0;
                for (int q = 0; q < NUM_PORTS; q++) begin
                    for (int k = 0; k < NUM_VCS; k++) begin
                        if (out_gnt[q][k][p*NUM_VCS+v]) in_win[p][v] = 1'b1;
                    end
                end
                for (int k = 0; k < NUM_VCS; k++) begin
                    if (in_gnt[p][v][k]) win_id[p][v] = VC_ID_BITS'(k);
                end
            end
        end
    end

    // ownership update: release on unlock, claim on grant
    always_comb begin
        busy_d  = busy_q;
        own_p_d = own_p_q;
        own_v_d = own_v_q;
        held_d  = held_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                alloc_d[p][v] = in_win[p][v];
                id_d[p][v]    = in_win[p][v] ? win_id[p][v] : '0;
                if (unlock_vc[p][v] && held_q[p][v]) begin
                    held_d[p][v] = 1'b0;
                    for (int q = 0; q < NUM_PORTS; q++) begin
                        for (int k = 0; k < NUM_VCS; k++) begin
                            if (busy_q[q][k]
                                && own_p_q[q][k] == PORT_BITS'(p)
                                && own_v_q[q][k] == VC_ID_BITS'(v))
                                busy_d[q][k] = 1'b0;
                        end
                    end
                end
                if (in_win[p][v]) held_d[p][v] = 1'b1;
            end
        end
        for (int q = 0; q < NUM_PORTS; q++) begin
            for (int k = 0; k < NUM_VCS; k++) begin
                for (int i = 0; i < NI; i++) begin
                    if (out_gnt[q][k][i]) begin
                        busy_d[q][k]  = 1'b1;
                        own_p_d[q][k] = PORT_BITS'(i / NUM_VCS);
                        own_v_d[q][k] = VC_ID_BITS'(i % NUM_VCS);
                    end
                end
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    busy_q[p][v]  <= 1'b0;
                    own_p_q[p][v] <= '0;
                    own_v_q[p][v] <= '0;
                    held_q[p][v]  <= 1'b0;
                    alloc_q[p][v] <= 1'b0;
                    id_q[p][v]    <= '0;
                end
            end
        end else begin
            busy_q  <= busy_d;
            own_p_q <= own_p_d;
            own_v_q <= own_v_d;
            held_q  <= held_d;
            alloc_q <= alloc_d;
            id_q    <= id_d;
        end
    end

    assign vc_allocated    = alloc_q;
    assign vc_allocated_id = id_q;

`ifdef VA_VC_FREE_OBS_EN
    // free flags straight from the busy register
    always_comb begin
        for (int q = 0; q < NUM_PORTS; q++) begin
            for (int k = 0; k < NUM_VCS; k++) begin
                out_vc_free[q][k] = !busy_q[q][k];
            end
        end
    end
`endif

endmodule
